// File: rtl/conv_1x1_ofm_writer.sv
// conv_1x1_ofm_writer: gathers four PE lane partial sums, requantises them to bytes,
// and writes packed 32-bit words to OFM memory at sequential addresses for one layer.
// Ports: clk/reset (sync, active-high); cal_start with num_filter/num_pixel/ofm_base/shift
// layer config; PE_finish/psum lane inputs; ofm_wr_en/ofm_wr_ready/ofm_addr/ofm_wr_data
// write handshake; busy/done/err_overrun status.
// Build option: define OFM_RELU_EN to clamp lanes to unsigned 0..255 (ReLU) instead of
// signed -128..127.
module conv_1x1_ofm_writer #(
  parameter int PSUM_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cal_start,
  input  logic [7:0]          num_filter,
  input  logic [15:0]         num_pixel,
  input  logic [ADDR_W-1:0]   ofm_base,
  input  logic [4:0]          shift,
  input  logic [3:0]          PE_finish,
  input  logic [4*PSUM_W-1:0] psum,
  output logic                ofm_wr_en,
  input  logic                ofm_wr_ready,
  output logic [ADDR_W-1:0]   ofm_addr,
  output logic [31:0]         ofm_wr_data,
  output logic                busy,
  output logic                done,
  output logic                err_overrun
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0] state, state_n;
  logic [3:0] mask, cap;
  logic signed [PSUM_W-1:0] hold [4];
  logic [7:0] nf, filter_cnt;
  logic [15:0] np, pixel_cnt;
  logic [4:0] sh;
  logic [31:0] word;
  logic active, start, full, accept, grp_last, last, load, ovr;

  function automatic logic [7:0] quant(input logic signed [PSUM_W-1:0] v, input logic [4:0] s);
    logic signed [PSUM_W-1:0] t;
    t = v >>> s;
`ifdef OFM_RELU_EN
    return t[PSUM_W-1] ? 8'h00 : t > $signed(PSUM_W'(255)) ? 8'hFF : t[7:0];
`else
    return t < $signed(PSUM_W'(-128)) ? 8'h80 : t > $signed(PSUM_W'(127)) ? 8'h7F : t[7:0];
`endif
  endfunction

  always_comb begin
    word = '0;
    for (int i = 0; i < 4; i++) word[8*i +: 8] = quant(hold[i], sh);
  end

  assign active   = state == COLLECT || state == WRITE;
  assign start    = state == IDLE && cal_start;
  assign full     = mask == 4'hF;
  assign accept   = state == WRITE && ofm_wr_en && ofm_wr_ready;
  assign grp_last = {1'b0, filter_cnt} + 9'd4 == {1'b0, nf};
  assign last     = grp_last && ({1'b0, pixel_cnt} + 17'd1 == {1'b0, np});
  // A full mask is turned into the next word either from COLLECT or straight after an
  // accept, so back-to-back words need no COLLECT cycle in between.
  assign load     = full && (state == COLLECT || (accept && !last));
  assign cap      = active ? PE_finish & ~mask : 4'h0;
  assign ovr      = active && |(PE_finish & mask);
  assign busy     = active;
  assign done     = state == DONE;

  always_comb begin
    state_n = state == IDLE    ? (cal_start ? (num_filter == 8'd0 || num_pixel == 16'd0 ? DONE : COLLECT) : IDLE) :
              state == COLLECT ? (full ? WRITE : COLLECT) :
              state == WRITE   ? (accept ? (last ? DONE : full ? WRITE : COLLECT) : WRITE) :
                                 IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mask        <= 4'h0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
      nf          <= 8'd0;
      np          <= 16'd0;
      sh          <= 5'd0;
      filter_cnt  <= 8'd0;
      pixel_cnt   <= 16'd0;
      ofm_wr_en   <= 1'b0;
      ofm_addr    <= '0;
      ofm_wr_data <= 32'd0;
      err_overrun <= 1'b0;
    end else begin
      state     <= state_n;
      ofm_wr_en <= state_n == WRITE;
      mask      <= (start || load) ? 4'h0 : mask | cap;
      for (int i = 0; i < 4; i++) if (cap[i]) hold[i] <= $signed(psum[i*PSUM_W +: PSUM_W]);
      if (load) ofm_wr_data <= word;
      if (start) begin
        nf          <= num_filter;
        np          <= num_pixel;
        sh          <= shift;
        ofm_addr    <= ofm_base;
        filter_cnt  <= 8'd0;
        pixel_cnt   <= 16'd0;
        err_overrun <= 1'b0;
      end else begin
        if (ovr) err_overrun <= 1'b1;
        // Words are laid out contiguously, so base + pixel*num_filter + filter
        // advances by exactly one word per accepted write.
        if (accept) begin
          ofm_addr   <= ofm_addr + ADDR_W'(4);
          filter_cnt <= grp_last ? 8'd0 : filter_cnt + 8'd4;
          if (grp_last) pixel_cnt <= pixel_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_1x1_ofm_writer.sv
// tb_conv_1x1_ofm_writer: directed scoreboard bench for conv_1x1_ofm_writer.
module tb_conv_1x1_ofm_writer;
  logic clk = 0, reset = 1, cal_start = 0, ofm_wr_ready = 1;
  logic [7:0] num_filter = 0;
  logic [15:0] num_pixel = 0;
  logic [31:0] ofm_base = 0;
  logic [4:0] shift = 0;
  logic [3:0] PE_finish = 0;
  logic [127:0] psum = 0;
  logic ofm_wr_en, busy, done, err_overrun;
  logic [31:0] ofm_addr, ofm_wr_data, last_data = 0;
  logic [63:0] sb [$];
  logic [63:0] exp_w;
  int total = 0, bad = 0, nwr = 0, ndone = 0;

  conv_1x1_ofm_writer dut (
    .clk(clk), .reset(reset), .cal_start(cal_start), .num_filter(num_filter),
    .num_pixel(num_pixel), .ofm_base(ofm_base), .shift(shift), .PE_finish(PE_finish),
    .psum(psum), .ofm_wr_en(ofm_wr_en), .ofm_wr_ready(ofm_wr_ready), .ofm_addr(ofm_addr),
    .ofm_wr_data(ofm_wr_data), .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] q8(input longint v, input int s);
    longint t;
    t = v >>> s;
`ifdef OFM_RELU_EN
    return t < 0 ? 8'h00 : t > 255 ? 8'hFF : 8'(t);
`else
    return t < -128 ? 8'h80 : t > 127 ? 8'h7F : 8'(t);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) ndone++;
    if (!reset && ofm_wr_en && ofm_wr_ready) begin
      nwr++;
      last_data = ofm_wr_data;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write: got addr %h data %h want none", ofm_addr, ofm_wr_data);
      end
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        chk("wr_addr", ofm_addr, exp_w[63:32]);
        chk("wr_data", ofm_wr_data, exp_w[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int nf, input int np, input logic [31:0] base, input int s);
    num_filter = 8'(nf); num_pixel = 16'(np); ofm_base = base; shift = 5'(s);
    cal_start = 1;
    tick();
    cal_start = 0;
  endtask

  task automatic lanes(input logic [3:0] m, input longint a0, a1, a2, a3);
    PE_finish = m;
    psum = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    tick();
    PE_finish = 0;
  endtask

  task automatic push(input logic [31:0] addr, input longint a0, a1, a2, a3, input int s);
    sb.push_back({addr, q8(a3, s), q8(a2, s), q8(a1, s), q8(a0, s)});
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && !done; i++) tick();
    chk(tag, {31'd0, done}, 32'd1);
    tick();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_sb"}, sb.size(), 32'd0);
  endtask

  initial begin
    longint v [4];
    int d0, w0;
    tick(); tick();
    reset = 0;
    chk("rst_en", {31'd0, ofm_wr_en}, 0);
    chk("rst_stat", {29'd0, busy, done, err_overrun}, 0);
    chk("rst_addr", ofm_addr, 0);
    chk("rst_data", ofm_wr_data, 0);

    // single word, mixed saturation
    start(4, 1, 32'h100, 0);
    chk("busy", {31'd0, busy}, 1);
    push(32'h100, 5, -3, 300, 127, 0);
    lanes(4'hF, 5, -3, 300, 127);
    wait_done("done033");
`ifdef OFM_RELU_EN
    chk("data033", last_data, 32'h7FFF0005);
`else
    chk("data033", last_data, 32'h7F7FFD05);
`endif

    // two pixels of eight filters, memory always ready
    d0 = ndone; w0 = nwr;
    start(8, 2, 32'h100, 0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) v[j] = longint'($urandom_range(0, 600)) - 300;
      push(32'h100 + 32'(4 * k), v[0], v[1], v[2], v[3], 0);
      lanes(4'hF, v[0], v[1], v[2], v[3]);
      tick(); tick();
    end
    wait_done("done034");
    chk("ndone034", ndone - d0, 1);
    chk("nwr034", nwr - w0, 4);

    // shift before saturation
    start(4, 1, 32'h200, 4);
    push(32'h200, 1024, 16, 16, 16, 4);
    lanes(4'hF, 1024, 16, 16, 16);
    wait_done("done035");
    chk("data035", last_data, 32'h01010140);

    // backpressure while the next word fills up; busy cal_start ignored
    ofm_wr_ready = 0;
    start(4, 2, 32'h300, 0);
    push(32'h300, 1, 2, 3, 4, 0);
    push(32'h304, -200, 9, 200, -7, 0);
    lanes(4'hF, 1, 2, 3, 4);
    tick();
    cal_start = 1; num_filter = 8'd16; ofm_base = 32'hFFF0;
    lanes(4'hF, -200, 9, 200, -7);
    cal_start = 0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_en", {31'd0, ofm_wr_en}, 1);
      chk("stall_addr", ofm_addr, 32'h300);
      chk("stall_data", ofm_wr_data, {q8(4, 0), q8(3, 0), q8(2, 0), q8(1, 0)});
      if (k < 3) tick();
    end
    ofm_wr_ready = 1;
    tick();
    chk("b2b_en", {31'd0, ofm_wr_en}, 1);
    chk("b2b_addr", ofm_addr, 32'h304);
    chk("no_ovr036", {31'd0, err_overrun}, 0);
    wait_done("done036");

    // lane 2 overrun keeps first value and is sticky
    start(4, 1, 32'h400, 0);
    push(32'h400, 11, 22, 10, 33, 0);
    lanes(4'b0100, 0, 0, 10, 0);
    lanes(4'b0100, 0, 0, 99, 0);
    chk("ovr_set", {31'd0, err_overrun}, 1);
    lanes(4'b1011, 11, 22, 0, 33);
    wait_done("done037");
    chk("ovr_sticky", {31'd0, err_overrun}, 1);

    // reset mid-handshake, then empty layer
    ofm_wr_ready = 0;
    start(4, 1, 32'h500, 0);
    chk("ovr_clr", {31'd0, err_overrun}, 0);
    lanes(4'hF, 1, 1, 1, 1);
    tick();
    chk("pre_rst_en", {31'd0, ofm_wr_en}, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_en", {31'd0, ofm_wr_en}, 0);
    chk("mid_rst_busy", {30'd0, busy, done}, 0);
    chk("mid_rst_addr", ofm_addr, 0);
    w0 = nwr;
    ofm_wr_ready = 1;
    start(0, 5, 32'h600, 0);
    chk("zero_done", {30'd0, busy, done}, 1);
    tick();
    chk("zero_idle", {30'd0, busy, done}, 0);
    chk("zero_nwr", nwr - w0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
